// File: rtl/storage_arb_pkg.sv
// rtl/storage_arb_pkg.sv - shared types and constants for the storage write arbiter
package storage_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    localparam int NAME_BYTES  = 8;

    localparam int REQ_INPUT   = 0;
    localparam int REQ_GEN     = 1;
    localparam int REQ_COMPUTE = 2;

endpackage

// File: rtl/storage_write_arbiter_rr_pick.sv
// rtl/storage_write_arbiter_rr_pick.sv - combinational round-robin winner search from a pointer
module rr_pick
    import storage_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    int cand;

    // Walk the search order backwards so the last hit is the first candidate after ptr_i.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(ptr_i) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (req_i[cand]) begin
                idx_o   = IDX_W'(cand);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/storage_write_arbiter.sv
// rtl/storage_write_arbiter.sv - round-robin owner of the storage manager's single matrix write port
module storage_write_arbiter
    import storage_arb_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_write_request,
    input  logic [NUM_REQ*3-1:0]          req_matrix_id,
    input  logic [NUM_REQ*8-1:0]          req_actual_rows,
    input  logic [NUM_REQ*8-1:0]          req_actual_cols,
    input  logic [NUM_REQ*64-1:0]         req_matrix_name,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
    input  logic [NUM_REQ-1:0]            req_data_valid,
    output logic [NUM_REQ-1:0]            req_write_ready,
    output logic [NUM_REQ-1:0]            req_write_done,
    output logic [NUM_REQ-1:0]            req_writer_ready,
    output logic                          write_request,
    output logic                          data_valid,
    output logic [2:0]                    matrix_id,
    output logic [7:0]                    actual_rows,
    output logic [7:0]                    actual_cols,
    output logic [7:0]                    matrix_name [0:NAME_BYTES-1],
    output logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          write_ready,
    input  logic                          write_done,
    input  logic                          writer_ready,
    output logic                          busy,
    output logic [OW-1:0]                 owner,
    output logic                          timeout
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    arb_state_t                state_q, state_d;
    logic [OW-1:0]             owner_q, owner_d, rr_q, rr_d, pick_idx;
    logic                      pick_valid, ws_q, ws_d;
    logic [CW-1:0]             wd_q, wd_d, wd_cnt;
    logic                      wd_expire, sm_active;
    logic                      sel_req, sel_dv;
    logic [2:0]                sel_id;
    logic [7:0]                sel_rows, sel_cols;
    logic [NAME_BYTES*8-1:0]   sel_name;
    logic [DATA_WIDTH-1:0]     sel_data;
    logic [NUM_REQ-1:0]        own_mask;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(OW)) u_pick (
        .req_i   (req_write_request),
        .ptr_i   (rr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        sel_req  = 1'b0;
        sel_dv   = 1'b0;
        sel_id   = '0;
        sel_rows = '0;
        sel_cols = '0;
        sel_name = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == OW'(i)) begin
                sel_req  = req_write_request[i];
                sel_dv   = req_data_valid[i];
                sel_id   = req_matrix_id[3*i +: 3];
                sel_rows = req_actual_rows[8*i +: 8];
                sel_cols = req_actual_cols[8*i +: 8];
                sel_name = req_matrix_name[NAME_BYTES*8*i +: NAME_BYTES*8];
                sel_data = req_data_in[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    // Everything downstream and every routed handshake is gated by GRANT, so IDLE and RELEASE read as zero.
    always_comb begin
        own_mask         = NUM_REQ'(1) << owner_q;
        write_request    = 1'b0;
        data_valid       = 1'b0;
        matrix_id        = '0;
        actual_rows      = '0;
        actual_cols      = '0;
        data_in          = '0;
        req_write_ready  = '0;
        req_write_done   = '0;
        req_writer_ready = '0;
        for (int b = 0; b < NAME_BYTES; b++) begin
            matrix_name[b] = '0;
        end
        if (state_q == ST_GRANT) begin
            write_request    = sel_req;
            data_valid       = sel_dv;
            matrix_id        = sel_id;
            actual_rows      = sel_rows;
            actual_cols      = sel_cols;
            data_in          = sel_data;
            req_write_ready  = own_mask & {NUM_REQ{write_ready}};
            req_write_done   = own_mask & {NUM_REQ{write_done}};
            req_writer_ready = own_mask & {NUM_REQ{writer_ready}};
            for (int b = 0; b < NAME_BYTES; b++) begin
                matrix_name[b] = sel_name[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        ws_d      = ws_q;
        wd_d      = wd_q;
        timeout   = 1'b0;
        sm_active = sel_dv | write_ready | writer_ready;
        wd_cnt    = sm_active ? '0 : wd_q + 1'b1;
        wd_expire = (TIMEOUT_CYCLES != 0) && (wd_cnt == CW'(TIMEOUT_CYCLES));
        case (state_q)
            ST_IDLE: begin
                ws_d = 1'b0;
                wd_d = '0;
                if (pick_valid) begin
                    owner_d = pick_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                ws_d = ws_q | write_ready;
                wd_d = wd_cnt;
                // write_done outranks the watchdog so a completed transfer never reports a timeout.
                if (write_done) begin
                    state_d = ST_RELEASE;
                end else if (wd_expire) begin
                    timeout = 1'b1;
                    state_d = ST_RELEASE;
                end else if (!sel_req && !ws_q) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                rr_d    = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            ws_q    <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            ws_q    <= ws_d;
            wd_q    <= wd_d;
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign owner = owner_q;

endmodule
